// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with a TX FIFO.
//   The CPU pushes bytes through TXDATA. They are queued and sent LSB first on tx,
//   as 8N1, or as 8E1 when UART_TX_PARITY_EN is defined.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   sel      decoder hit for this peripheral's window
//   addr     byte offset in the window; addr[3:2] selects the register
//   wdata    CPU store data
//   wenable  CPU store strobe, qualified by sel
//   rdata    combinational read data, 0 when sel=0
//   tx       serial line, idle high, driven from a register
//   tx_idle  1 when the FIFO is empty and the FSM is idle (registered)
//
// Register map (addr[3:2]):
//   0 TXDATA  (W)  push wdata[7:0]; reads 0
//   1 STATUS  (R)  {bit8 parity_en, [7:4] count (sat 15), overflow, empty, full, busy};
//                  any write clears overflow
//   2 BAUDDIV (RW) bit period in clocks; written values < 2 are stored as 2
//   3 reserved
module uart_tx_mmio #(
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic        wenable,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_idle
);

    localparam int unsigned DEFAULT_DIV = CLK_HZ / BAUD;
    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W       = PTR_W + 1;
    localparam int unsigned DIV_W       = 16;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   lat_q, lat_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         data_q, data_d;
    logic               tx_q, tx_d;
    logic               ovf_q, ovf_d;
    logic               idle_q, idle_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic               wr_txdata_c, wr_status_c, wr_baud_c;
    logic               full_c, empty_c, pop_c, accept_c, load_c;
    logic [3:0]         cnt_sat_c;
    logic [31:0]        status_c;
    logic               unused_c;

    // Register-write decode
    assign wr_txdata_c = sel & wenable & (addr[3:2] == 2'd0);
    assign wr_status_c = sel & wenable & (addr[3:2] == 2'd1);
    assign wr_baud_c   = sel & wenable & (addr[3:2] == 2'd2);

    assign full_c   = (count_q == DEPTH_C);
    assign empty_c  = (count_q == '0);
    // A push into a full FIFO still fits when the FSM pops in the same cycle
    assign accept_c = wr_txdata_c & (~full_c | pop_c);

    assign unused_c = ^{addr[1:0], wdata[31:16]};

    // Next-state and serial output
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        lat_d   = lat_q;
        tx_d    = tx_q;
        pop_c   = 1'b0;
        load_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty_c) load_c = 1'b1;
            end
            S_START: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    cnt_d   = lat_q - 16'd1;
                    tx_d    = data_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = lat_q - 16'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == '0) begin
                    state_d = S_STOP;
                    cnt_d   = lat_q - 16'd1;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (!empty_c) begin
                        load_c = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame start: pop a byte and latch the bit period for the whole frame
        if (load_c) begin
            pop_c   = 1'b1;
            data_d  = mem_q[rd_ptr_q];
            lat_d   = div_q;
            cnt_d   = div_q - 16'd1;
            state_d = S_START;
            tx_d    = 1'b0;
        end
    end

    // FIFO bookkeeping, overflow flag and BAUDDIV register
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        div_d    = div_q;
        if (accept_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(accept_c) - CNT_W'(pop_c);
        if (wr_status_c)
            ovf_d = 1'b0;
        else if (wr_txdata_c && !accept_c)
            ovf_d = 1'b1;
        if (wr_baud_c)
            div_d = (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
        idle_d = (state_d == S_IDLE) && (count_d == '0);
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= DIV_W'(DEFAULT_DIV);
            lat_q    <= DIV_W'(DEFAULT_DIV);
            bit_q    <= '0;
            data_q   <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            idle_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            lat_q    <= lat_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
            idle_q   <= idle_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (accept_c) mem_q[wr_ptr_q] <= wdata[7:0];
    end

    // STATUS word; count saturates at 15 for deep FIFOs
    always_comb begin
        if (32'(count_q) > 32'd15)
            cnt_sat_c = 4'hF;
        else
            cnt_sat_c = 4'(count_q);
        status_c = {23'd0, PAR_EN, cnt_sat_c, ovf_q, empty_c, full_c, (state_q != S_IDLE)};
    end

    // Combinational read mux
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr[3:2])
                2'd1:    rdata = status_c;
                2'd2:    rdata = {16'd0, div_q};
                default: rdata = '0;
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_idle = idle_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio: register-access vector table plus directed
// serial-frame sequences. Checks are sampled on the falling clock edge.
module tb_uart_tx_mmio;

    localparam logic [3:0] A_TX   = 4'h0;
    localparam logic [3:0] A_STAT = 4'h4;
    localparam logic [3:0] A_BAUD = 4'h8;
`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] PAR = 32'h100;
    localparam int          FB  = 11;
`else
    localparam logic [31:0] PAR = 32'h0;
    localparam int          FB  = 10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic        wenable = 1'b0;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_idle;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_q[$];

    uart_tx_mmio dut (
        .clk     (clk),
        .reset   (reset),
        .sel     (sel),
        .addr    (addr),
        .wdata   (wdata),
        .wenable (wenable),
        .rdata   (rdata),
        .tx      (tx),
        .tx_idle (tx_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wenable = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; wenable = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wenable = 1'b0; addr = a;
        #1 d = rdata;
        sel = 1'b0;
    endtask

    task automatic add_level(input logic v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic add_frame(input logic [7:0] b, input int div);
        add_level(1'b0, div);
        for (int i = 0; i < 8; i++) add_level(b[i], div);
`ifdef UART_TX_PARITY_EN
        add_level(^b, div);
`endif
        add_level(1'b1, div);
    endtask

    // Samples tx now and then once per falling edge until the expected queue drains
    task automatic check_tx(input string nm);
        int k = 0;
        while (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            chk($sformatf("%s[%0d]", nm, k), 32'(tx), 32'(e));
            k++;
            @(negedge clk);
        end
    endtask

    vec_t vt[17];
    logic [31:0] r;
    int n;

    initial begin
        vt[0]  = '{1'b1, 1'b0, A_STAT, 32'h0,        32'h04 | PAR, "status_rst"};
        vt[1]  = '{1'b1, 1'b0, A_BAUD, 32'h0,        32'd217,      "baud_rst"};
        vt[2]  = '{1'b1, 1'b0, A_TX,   32'h0,        32'h0,        "txdata_rd"};
        vt[3]  = '{1'b1, 1'b0, 4'hC,   32'h0,        32'h0,        "rsvd_rd"};
        vt[4]  = '{1'b0, 1'b0, A_BAUD, 32'h0,        32'h0,        "nosel_rd"};
        vt[5]  = '{1'b1, 1'b1, A_BAUD, 32'h00012345, 32'h0,        "wr"};
        vt[6]  = '{1'b1, 1'b0, 4'h9,   32'h0,        32'h2345,     "baud_trunc"};
        vt[7]  = '{1'b1, 1'b1, A_BAUD, 32'h1,        32'h0,        "wr"};
        vt[8]  = '{1'b1, 1'b0, A_BAUD, 32'h0,        32'h2,        "baud_min1"};
        vt[9]  = '{1'b1, 1'b1, 4'hA,   32'hFFFF0000, 32'h0,        "wr"};
        vt[10] = '{1'b1, 1'b0, A_BAUD, 32'h0,        32'h2,        "baud_min0"};
        vt[11] = '{1'b1, 1'b1, A_BAUD, 32'h3,        32'h0,        "wr"};
        vt[12] = '{1'b0, 1'b1, A_BAUD, 32'h55,       32'h0,        "wr"};
        vt[13] = '{1'b1, 1'b1, 4'hC,   32'h77,       32'h0,        "wr"};
        vt[14] = '{1'b1, 1'b0, A_BAUD, 32'h0,        32'h3,        "baud_keep"};
        vt[15] = '{1'b0, 1'b1, A_TX,   32'h11,       32'h0,        "wr"};
        vt[16] = '{1'b1, 1'b0, A_STAT, 32'h0,        32'h04 | PAR, "status_nopush"};

        // Reset state
        repeat (3) @(negedge clk);
        chk("tx_in_reset", 32'(tx), 32'h1);
        chk("idle_in_reset", 32'(tx_idle), 32'h1);
        reset = 1'b0;
        @(negedge clk);
        chk("tx_after_reset", 32'(tx), 32'h1);

        // Register-access table
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            sel = vt[i].s; wenable = vt[i].w; addr = vt[i].a; wdata = vt[i].d;
            if (!vt[i].w) begin
                #1 chk(vt[i].nm, rdata, vt[i].exp);
            end
            @(posedge clk);
            #1 sel = 1'b0; wenable = 1'b0;
        end
        chk("tx_quiet", 32'(tx), 32'h1);

        // Single 0x55 frame at BAUDDIV=4
        wr(A_BAUD, 32'd4);
        wr(A_TX, 32'h55);
        chk("idle_drop", 32'(tx_idle), 32'h0);
        @(negedge clk);
        add_frame(8'h55, 4);
        check_tx("f55");
        chk("idle_after_55", 32'(tx_idle), 32'h1);

        // Back-to-back 0x00, 0xFF at BAUDDIV=2
        wr(A_BAUD, 32'd2);
        @(negedge clk);
        sel = 1'b1; wenable = 1'b1; addr = A_TX; wdata = 32'h00;
        @(negedge clk);
        wdata = 32'hFF;
        @(negedge clk);
        wenable = 1'b0; addr = A_STAT;
        #1 chk("b2b_count", 32'(rdata[7:4]), 32'd1);
        chk("b2b_busy", 32'(rdata[0]), 32'd1);
        sel = 1'b0;
        add_frame(8'h00, 2);
        add_frame(8'hFF, 2);
        check_tx("b2b");
        chk("idle_after_b2b", 32'(tx_idle), 32'h1);

        // Overflow: 10 writes at BAUDDIV=100, the 10th is dropped
        wr(A_BAUD, 32'd100);
        @(negedge clk);
        sel = 1'b1; wenable = 1'b1; addr = A_TX; wdata = 32'd1;
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            wdata = 32'(i);
        end
        @(negedge clk);
        wenable = 1'b0; addr = A_STAT;
        #1 chk("ovf_status_full", rdata, 32'h8B | PAR);
        sel = 1'b0;
        for (int i = 1; i <= 9; i++) add_frame(8'(i), 100);
        repeat (8) void'(exp_q.pop_front());
        check_tx("ovf");
        rd(A_STAT, r);
        chk("ovf_status_done", r, 32'h0C | PAR);
        wr(A_STAT, 32'h0);
        rd(A_STAT, r);
        chk("ovf_cleared", r, 32'h04 | PAR);

        // BAUDDIV clamp, then a mid-frame change that only affects the next frame
        wr(A_BAUD, 32'd0);
        rd(A_BAUD, r);
        chk("baud_clamp", r, 32'd2);
        @(negedge clk);
        sel = 1'b1; wenable = 1'b1; addr = A_TX; wdata = 32'hA5;
        @(negedge clk);
        wdata = 32'h3C;
        @(negedge clk);
        sel = 1'b0; wenable = 1'b0;
        add_frame(8'hA5, 2);
        add_frame(8'h3C, 8);
        fork
            check_tx("midbaud");
            begin
                repeat (5) @(negedge clk);
                wr(A_BAUD, 32'd8);
            end
        join
        rd(A_BAUD, r);
        chk("baud_8", r, 32'd8);

        // Reset during data bit 3 of 0x96 (bit3 = 0)
        wr(A_TX, 32'h96);
        @(negedge clk);
        add_frame(8'h96, 8);
        while (exp_q.size() > 36) void'(exp_q.pop_back());
        check_tx("pre_rst");
        chk("bit3_low", 32'(tx), 32'h0);
        reset = 1'b1;
        #1 chk("rst_tx", 32'(tx), 32'h1);
        chk("rst_idle", 32'(tx_idle), 32'h1);
        sel = 1'b1; wenable = 1'b0; addr = A_STAT;
        #1 chk("rst_status", rdata, 32'h04 | PAR);
        addr = A_BAUD;
        #1 chk("rst_baud", rdata, 32'd217);
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_tx", 32'(tx), 32'h1);

        // Frame length for 0x07 at BAUDDIV=4: tx_idle low from the write edge to frame end
        wr(A_BAUD, 32'd4);
        wr(A_TX, 32'h07);
        n = 0;
        while (tx_idle == 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("len_07", 32'(n), 32'(1 + FB * 4));
        chk("tx_end_07", 32'(tx), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
